alu_rs: RTL

- Integer reservation station sitting directly downstream of the issue stage.
- Accepts ALU ops when the issue stage asserts its RS enable, together with operand values/ready bits/ROB-tag dependencies.
- Snoops the CDB to wake waiting operands.
- Dispatches ready ops one per cycle to the ALU through a valid/ready output register.
- Backpressures issue through full_o.

---
 rtl/rs_pkg.sv | 36 +++
 rtl/rs_pick.sv | 16 +
 rtl/alu_rs.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the integer reservation station.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Entry fields: busy, op, ROB tag, two operands (value/ready/producer tag).
package rs_pkg;

    localparam int RS_XLEN    = 32;
    localparam int RS_TAG_W   = 4;
    localparam int RS_ALUOP_W = 4;

    // ALU operation encodings shared with the issue stage and the ALU.
    localparam logic [RS_ALUOP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [RS_ALUOP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [RS_ALUOP_W-1:0] ALU_AND  = 4'd2;
    localparam logic [RS_ALUOP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [RS_ALUOP_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [RS_ALUOP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [RS_ALUOP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [RS_ALUOP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [RS_ALUOP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [RS_ALUOP_W-1:0] ALU_SLTU = 4'd9;

    // One reservation-station slot. Widths follow the package defaults;
    // the alu_rs width parameters must stay equal to them.
    typedef struct packed {
        logic                  busy;
        logic [RS_ALUOP_W-1:0] op;
        logic [RS_TAG_W-1:0]   tag;
        logic [RS_XLEN-1:0]    v1;
        logic                  r1;
        logic [RS_TAG_W-1:0]   q1;
        logic [RS_XLEN-1:0]    v2;
        logic                  r2;
        logic [RS_TAG_W-1:0]   q2;
    } rs_entry_t;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority picker: N-bit request vector -> one-hot grant + valid.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports req_i (in), gnt_o (one-hot out), vld_o (any request).
module rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         vld_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + N'(1));
    assign vld_o = |req_i;

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: issue alloc, CDB wakeup/bypass, lowest-index dispatch.
// Latency: ready-at-issue op dispatches one edge after allocation; CDB-woken op one edge after wakeup.
// Backpressure: full_o stalls issue; ex_* output register holds while ex_valid && !ex_ready.
// Ports: clk/rst (async active-low), flush, in_* issue write, cdb_* broadcast,
//        full_o/count_o occupancy, ex_* dispatch with ex_valid/ex_ready handshake.
module alu_rs
    import rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int XLEN    = RS_XLEN,
    parameter int TAG_W   = RS_TAG_W,
    parameter int ALUOP_W = RS_ALUOP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_en,
    input  logic [ALUOP_W-1:0]       in_alu_op,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [XLEN-1:0]          in_rs1_value,
    input  logic                     in_rs1_rdy,
    input  logic [TAG_W-1:0]         in_rs1_q,
    input  logic [XLEN-1:0]          in_rs2_value,
    input  logic                     in_rs2_rdy,
    input  logic [TAG_W-1:0]         in_rs2_q,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [XLEN-1:0]          cdb_value,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [ALUOP_W-1:0]       ex_alu_op,
    output logic [XLEN-1:0]          ex_a,
    output logic [XLEN-1:0]          ex_b,
    output logic [TAG_W-1:0]         ex_tag
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    rs_entry_t              ent_q [DEPTH];
    rs_entry_t              ent_d [DEPTH];
    logic                   ex_valid_q, ex_valid_d;
    logic [ALUOP_W-1:0]     ex_op_q,    ex_op_d;
    logic [XLEN-1:0]        ex_a_q,     ex_a_d;
    logic [XLEN-1:0]        ex_b_q,     ex_b_d;
    logic [TAG_W-1:0]       ex_tag_q,   ex_tag_d;

    logic [DEPTH-1:0]       free_req, alloc_gnt;
    logic [DEPTH-1:0]       rdy_req,  sel_gnt;
    logic                   alloc_vld, sel_vld;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   out_free;
    logic                   do_alloc;
    logic                   byp1, byp2;
    rs_entry_t              pick;

    // Occupancy and candidate vectors come from registered state only, so a
    // slot freed by dispatch this cycle is not reallocated until next cycle.
    always_comb begin
        count    = '0;
        free_req = '0;
        rdy_req  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count       = count + CNT_W'(ent_q[i].busy);
            free_req[i] = !ent_q[i].busy;
            rdy_req[i]  = ent_q[i].busy && ent_q[i].r1 && ent_q[i].r2;
        end
    end

    assign full = (count == CNT_W'(DEPTH));

    rs_pick #(.N(DEPTH)) u_alloc_pick (
        .req_i (free_req),
        .gnt_o (alloc_gnt),
        .vld_o (alloc_vld)
    );

    rs_pick #(.N(DEPTH)) u_sel_pick (
        .req_i (rdy_req),
        .gnt_o (sel_gnt),
        .vld_o (sel_vld)
    );

    assign out_free = !ex_valid_q || ex_ready;
    assign do_alloc = in_en && !full && alloc_vld;

    // Same-cycle CDB bypass for operands the issue stage saw as not ready.
    assign byp1 = !in_rs1_rdy && cdb_valid && (cdb_tag == in_rs1_q);
    assign byp2 = !in_rs2_rdy && cdb_valid && (cdb_tag == in_rs2_q);

    // Selected entry contents (one-hot grant, so at most one term matches).
    always_comb begin
        pick = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_gnt[i]) pick = ent_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            // Wakeup: both operands may capture the same broadcast.
            if (ent_q[i].busy && cdb_valid) begin
                if (!ent_q[i].r1 && ent_q[i].q1 == cdb_tag) begin
                    ent_d[i].v1 = cdb_value;
                    ent_d[i].r1 = 1'b1;
                end
                if (!ent_q[i].r2 && ent_q[i].q2 == cdb_tag) begin
                    ent_d[i].v2 = cdb_value;
                    ent_d[i].r2 = 1'b1;
                end
            end
            if (out_free && sel_gnt[i]) begin
                ent_d[i].busy = 1'b0;
            end
            // Allocation only targets slots that were free in registered state.
            if (do_alloc && alloc_gnt[i]) begin
                ent_d[i].busy = 1'b1;
                ent_d[i].op   = in_alu_op;
                ent_d[i].tag  = in_tag;
                ent_d[i].v1   = byp1 ? cdb_value : in_rs1_value;
                ent_d[i].r1   = in_rs1_rdy || byp1;
                ent_d[i].q1   = in_rs1_q;
                ent_d[i].v2   = byp2 ? cdb_value : in_rs2_value;
                ent_d[i].r2   = in_rs2_rdy || byp2;
                ent_d[i].q2   = in_rs2_q;
            end
            if (flush) begin
                ent_d[i].busy = 1'b0;
            end
        end

        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_tag_d   = ex_tag_q;
        if (out_free) begin
            ex_valid_d = sel_vld;
            if (sel_vld) begin
                ex_op_d  = pick.op;
                ex_a_d   = pick.v1;
                ex_b_d   = pick.v2;
                ex_tag_d = pick.tag;
            end
        end
        if (flush) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_tag_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_tag_q   <= ex_tag_d;
        end
    end

    assign full_o    = full;
    assign count_o   = count;
    assign ex_valid  = ex_valid_q;
    assign ex_alu_op = ex_op_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_tag    = ex_tag_q;

endmodule
